alu_control_pipe: RTL and testbench

//  Registered, handshaked successor of the single-cycle ALU control decoder for the pipelined RISC-V core.
//  - Accepts aluOp/funct7/funct3 from the ID stage and emits a registered ALU control code to EX.
//  - Decodes the full RV32I ALU op set (XOR, shifts, SLT/SLTU, I-type ALU) and flags illegal encodings.
//  - Optionally sequences multi-cycle M-extension ops by holding the stage for a fixed latency.

---
 rtl/alu_control_pipe.sv | 197 +++++++++++++++++++
 tb/tb_alu_control_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_pipe.sv
// alu_control_pipe: registered, valid/ready ALU control decoder between ID and EX
// of the pipelined RV32I core. Decodes aluOp/funct7/funct3 into a 4-bit ALU code
// (zero-extended to CTRL_W) and flags unsupported encodings. Illegal encodings are
// passed through as ADD with the illegal flag set.
// Optional feature macro: MULDIV_EN -- adds M-extension decode and holds the stage
// in a WAIT state for MUL_LAT / DIV_LAT cycles before presenting the result.
module alu_control_pipe #(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [6:0]        funct7,
  input  logic [2:0]        funct3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic              busy
);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_SLL  = 4'b0100;
  localparam logic [3:0] C_SRL  = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SRA  = 4'b0111;
  localparam logic [3:0] C_SLT  = 4'b1000;
  localparam logic [3:0] C_SLTU = 4'b1001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Elaboration-time sanity checks on the configuration.
  if (CTRL_W < 4) begin : g_bad_ctrl_w
    $error("alu_control_pipe: CTRL_W must be >= 4");
  end
  if (MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_lat
    $error("alu_control_pipe: MUL_LAT and DIV_LAT must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e            state_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              illegal_q;
  logic [CTRL_W-1:0] alu_ctrl_q;

  logic [3:0]        dec_code_d;
  logic              dec_illegal_d;
  logic              accept;

`ifdef MULDIV_EN
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0]  cnt_q;
  logic              dec_multi_d;
  logic [CNT_W-1:0]  dec_lat_d;
`endif

  // Base RV32I op selected by funct3 when funct7 carries no modifier.
  function automatic logic [3:0] base_code(input logic [2:0] f3);
    case (f3)
      3'b000:  base_code = C_ADD;
      3'b001:  base_code = C_SLL;
      3'b010:  base_code = C_SLT;
      3'b011:  base_code = C_SLTU;
      3'b100:  base_code = C_XOR;
      3'b101:  base_code = C_SRL;
      3'b110:  base_code = C_OR;
      default: base_code = C_AND;
    endcase
  endfunction

  // Combinational decode of the incoming fields; illegal encodings fall back to ADD.
  always_comb begin
    dec_code_d    = C_ADD;
    dec_illegal_d = 1'b0;
`ifdef MULDIV_EN
    dec_multi_d   = 1'b0;
    dec_lat_d     = '0;
`endif
    case (alu_op)
      2'b00: dec_code_d = C_ADD;
      2'b01: dec_code_d = C_SUB;
      2'b10: begin
        if (funct7 == F7_BASE) begin
          dec_code_d = base_code(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_code_d = C_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_code_d = C_SRA;
`ifdef MULDIV_EN
        end else if (funct7 == 7'b0000001) begin
          dec_multi_d = 1'b1;
          case (funct3)
            3'b000:  dec_code_d = 4'b1010;
            3'b001,
            3'b010,
            3'b011:  dec_code_d = 4'b1011;
            default: dec_code_d = {2'b11, funct3[1:0]};
          endcase
          dec_lat_d = funct3[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
`endif
        end else begin
          dec_illegal_d = 1'b1;
        end
      end
      default: begin
        case (funct3)
          3'b000: dec_code_d = C_ADD;
          3'b001: begin
            if (funct7 == F7_BASE) dec_code_d = C_SLL;
            else                   dec_illegal_d = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     dec_code_d = C_SRL;
            else if (funct7 == F7_ALT) dec_code_d = C_SRA;
            else                       dec_illegal_d = 1'b1;
          end
          default: dec_code_d = base_code(funct3);
        endcase
      end
    endcase
  end

  assign in_ready = (state_q == ST_EMPTY) | ((state_q == ST_FULL) & out_ready);
  assign accept   = in_valid & in_ready;

  // Stage FSM: EMPTY/FULL hold a single result, WAIT counts down a multi-cycle op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      alu_ctrl_q  <= '0;
      illegal_q   <= 1'b0;
`ifdef MULDIV_EN
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
`ifdef MULDIV_EN
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= ST_FULL;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`endif
        default: begin
          if (accept) begin
            alu_ctrl_q <= CTRL_W'(dec_code_d);
            illegal_q  <= dec_illegal_d;
`ifdef MULDIV_EN
            if (dec_multi_d && dec_lat_d != '0) begin
              state_q     <= ST_WAIT;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b1;
              cnt_q       <= dec_lat_d;
            end else
`endif
            begin
              state_q     <= ST_FULL;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end else if (state_q == ST_FULL && out_ready) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_control_pipe.sv
// tb_alu_control_pipe: directed scenarios plus randomized traffic for alu_control_pipe,
// checked against a transaction-level reference model of the stage.
// Honours the MULDIV_EN macro in the same way as the design.
module tb_alu_control_pipe;

  localparam int CTRL_W  = 4;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;
`ifdef MULDIV_EN
  localparam bit MD_ON = 1'b1;
`else
  localparam bit MD_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        alu_op = 2'b00;
  logic [6:0]        funct7 = 7'b0;
  logic [2:0]        funct3 = 3'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              illegal;
  logic              busy;

  int total = 0;
  int bad   = 0;

  // Reference model state: output slot contents and remaining multi-cycle wait.
  bit         mV = 1'b0;
  logic [3:0] mCtrl = 4'b0;
  bit         mIll = 1'b0;
  int         mWait = 0;

  logic [3:0] baseTab [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b1001,
                              4'b0011, 4'b0101, 4'b0001, 4'b0000};
  logic [3:0] mdTab   [8] = '{4'b1010, 4'b1011, 4'b1011, 4'b1011,
                              4'b1100, 4'b1101, 4'b1110, 4'b1111};

  always #5 clk = ~clk;

  alu_control_pipe #(
    .CTRL_W (CTRL_W),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .funct7   (funct7),
    .funct3   (funct3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_ctrl (alu_ctrl),
    .illegal  (illegal),
    .busy     (busy)
  );

  // Instruction-level meaning of the decode fields.
  function automatic void refDecode(input logic [1:0] op, input logic [6:0] f7,
                                    input logic [2:0] f3, output logic [3:0] code,
                                    output bit ill, output int lat);
    code = 4'b0010;
    ill  = 1'b0;
    lat  = 1;
    if (op == 2'b00) begin
      code = 4'b0010;
    end else if (op == 2'b01) begin
      code = 4'b0110;
    end else if (op == 2'b10) begin
      if (f7 == 7'h00)                      code = baseTab[f3];
      else if (f7 == 7'h20 && f3 == 3'd0)   code = 4'b0110;
      else if (f7 == 7'h20 && f3 == 3'd5)   code = 4'b0111;
      else if (f7 == 7'h01 && MD_ON) begin
        code = mdTab[f3];
        lat  = (f3 < 3'd4) ? MUL_LAT : DIV_LAT;
      end else                              ill = 1'b1;
    end else begin
      if (f3 == 3'd0)                       code = 4'b0010;
      else if (f3 == 3'd1 && f7 != 7'h00)   ill = 1'b1;
      else if (f3 == 3'd5 && f7 == 7'h20)   code = 4'b0111;
      else if (f3 == 3'd5 && f7 != 7'h00)   ill = 1'b1;
      else                                  code = baseTab[f3];
    end
    if (ill) code = 4'b0010;
  endfunction

  function automatic bit modelReady();
    return (!mV && mWait == 0) || (mV && out_ready);
  endfunction

  task automatic resetModel();
    mV = 1'b0; mCtrl = 4'b0; mIll = 1'b0; mWait = 0;
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input logic [6:0] f7,
                       input logic [2:0] f3, input bit ordy);
    in_valid = v; alu_op = op; funct7 = f7; funct3 = f3; out_ready = ordy;
    #1;
  endtask

  // Advance one clock and step the reference model with the inputs seen at that edge.
  task automatic cycle();
    logic [3:0] c;
    bit il, acc, cons;
    int lat;
    refDecode(alu_op, funct7, funct3, c, il, lat);
    acc  = in_valid && modelReady();
    cons = mV && out_ready;
    @(posedge clk);
    if (mWait > 0) begin
      mWait--;
      if (mWait == 0) mV = 1'b1;
    end else if (acc) begin
      mCtrl = c; mIll = il;
      if (lat > 1) begin mV = 1'b0; mWait = lat; end
      else mV = 1'b1;
    end else if (cons) begin
      mV = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%0b want=0", out_valid); end
    total++; if (alu_ctrl !== 4'b0) begin bad++; $display("[TB] FAIL rst_ctrl got=%b want=0000", alu_ctrl); end
    total++; if (illegal !== 1'b0) begin bad++; $display("[TB] FAIL rst_illegal got=%0b want=0", illegal); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%0b want=0", busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready got=%0b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_rst_valid got=%0b want=0", out_valid); end
  endtask

  task automatic test_load();
    drive(1'b1, 2'b00, 7'h55, 3'd6, 1'b1);
    cycle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL ld_valid got=%0b want=1", out_valid); end
    total++; if (alu_ctrl !== 4'b0010) begin bad++; $display("[TB] FAIL ld_ctrl got=%b want=0010", alu_ctrl); end
    total++; if (illegal !== 1'b0) begin bad++; $display("[TB] FAIL ld_illegal got=%0b want=0", illegal); end
    drive(1'b0, 2'b00, 7'h00, 3'd0, 1'b1);
    cycle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL ld_drain got=%0b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b01, 7'h00, 3'd0, 1'b1);
    cycle();
    total++; if (alu_ctrl !== 4'b0110 || out_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_beq got=%b/%0b want=0110/1", alu_ctrl, out_valid); end
    drive(1'b1, 2'b10, 7'h20, 3'd0, 1'b1);
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready1 got=%0b want=1", in_ready); end
    cycle();
    total++; if (alu_ctrl !== 4'b0110 || out_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_sub got=%b/%0b want=0110/1", alu_ctrl, out_valid); end
    drive(1'b1, 2'b10, 7'h00, 3'd4, 1'b1);
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready2 got=%0b want=1", in_ready); end
    cycle();
    total++; if (alu_ctrl !== 4'b0011 || out_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_xor got=%b/%0b want=0011/1", alu_ctrl, out_valid); end
    drive(1'b0, 2'b00, 7'h00, 3'd0, 1'b1);
    cycle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drain got=%0b want=0", out_valid); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 2'b10, 7'h00, 3'd7, 1'b0);
    cycle();
    drive(1'b1, 2'b10, 7'h00, 3'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++; if (alu_ctrl !== 4'b0000 || out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold%0d got=%b/%0b want=0000/1", i, alu_ctrl, out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready%0d got=%0b want=0", i, in_ready); end
      cycle();
    end
    drive(1'b1, 2'b10, 7'h00, 3'd4, 1'b1);
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release got=%0b want=1", in_ready); end
    cycle();
    total++; if (alu_ctrl !== 4'b0011 || out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_next got=%b/%0b want=0011/1", alu_ctrl, out_valid); end
    drive(1'b0, 2'b00, 7'h00, 3'd0, 1'b1);
    cycle();
  endtask

  task automatic test_illegal();
    drive(1'b1, 2'b10, 7'h7F, 3'd7, 1'b1);
    cycle();
    total++; if (alu_ctrl !== 4'b0010) begin bad++; $display("[TB] FAIL ill_ctrl got=%b want=0010", alu_ctrl); end
    total++; if (illegal !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("[TB] FAIL ill_flag got=%0b/%0b want=1/1", illegal, out_valid); end
    drive(1'b0, 2'b00, 7'h00, 3'd0, 1'b1);
    cycle();
    total++; if (illegal !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL ill_hold got=%0b/%0b want=1/0", illegal, out_valid); end
  endtask

  task automatic test_itype();
    drive(1'b1, 2'b11, 7'h20, 3'd5, 1'b1);
    cycle();
    total++; if (alu_ctrl !== 4'b0111 || illegal !== 1'b0) begin bad++; $display("[TB] FAIL srai got=%b/%0b want=0111/0", alu_ctrl, illegal); end
    drive(1'b1, 2'b11, 7'h20, 3'd0, 1'b1);
    cycle();
    total++; if (alu_ctrl !== 4'b0010 || illegal !== 1'b0) begin bad++; $display("[TB] FAIL addi got=%b/%0b want=0010/0", alu_ctrl, illegal); end
    drive(1'b1, 2'b11, 7'h20, 3'd1, 1'b1);
    cycle();
    total++; if (alu_ctrl !== 4'b0010 || illegal !== 1'b1) begin bad++; $display("[TB] FAIL slli_bad got=%b/%0b want=0010/1", alu_ctrl, illegal); end
    drive(1'b1, 2'b11, 7'h33, 3'd3, 1'b1);
    cycle();
    total++; if (alu_ctrl !== 4'b1001 || illegal !== 1'b0) begin bad++; $display("[TB] FAIL sltiu got=%b/%0b want=1001/0", alu_ctrl, illegal); end
    drive(1'b0, 2'b00, 7'h00, 3'd0, 1'b1);
    cycle();
  endtask

  task automatic test_muldiv();
`ifdef MULDIV_EN
    drive(1'b1, 2'b10, 7'h01, 3'd4, 1'b1);
    cycle();
    drive(1'b0, 2'b00, 7'h00, 3'd0, 1'b1);
    for (int i = 0; i < DIV_LAT; i++) begin
      total++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL div_wait%0d got busy/rdy/vld=%0b%0b%0b want=100", i, busy, in_ready, out_valid); end
      cycle();
    end
    total++; if (out_valid !== 1'b1 || alu_ctrl !== 4'b1100 || busy !== 1'b0) begin bad++; $display("[TB] FAIL div_done got=%0b/%b/%0b want=1/1100/0", out_valid, alu_ctrl, busy); end
    cycle();
    drive(1'b1, 2'b10, 7'h01, 3'd6, 1'b1);
    cycle();
    drive(1'b0, 2'b00, 7'h00, 3'd0, 1'b1);
    cycle();
    cycle();
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rem_busy got=%0b want=1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || alu_ctrl !== 4'b0 || illegal !== 1'b0) begin bad++; $display("[TB] FAIL midwait_rst got=%0b/%0b/%b/%0b want=0/0/0000/0", out_valid, busy, alu_ctrl, illegal); end
    resetModel();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_midwait got=%0b/%0b want=0/1", out_valid, in_ready); end
`else
    drive(1'b1, 2'b10, 7'h01, 3'd4, 1'b1);
    cycle();
    total++; if (illegal !== 1'b1 || alu_ctrl !== 4'b0010 || out_valid !== 1'b1) begin bad++; $display("[TB] FAIL md_off got=%0b/%b/%0b want=1/0010/1", illegal, alu_ctrl, out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL md_off_busy got=%0b want=0", busy); end
    drive(1'b0, 2'b00, 7'h00, 3'd0, 1'b1);
    cycle();
`endif
  endtask

  task automatic test_random();
    logic [6:0] f7;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      drive(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), f7,
            3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7));
      total++; if (in_ready !== modelReady()) begin bad++; $display("[TB] FAIL rnd_ready n=%0d got=%0b want=%0b", n, in_ready, modelReady()); end
      cycle();
      total++; if (out_valid !== mV) begin bad++; $display("[TB] FAIL rnd_valid n=%0d got=%0b want=%0b", n, out_valid, mV); end
      total++; if (busy !== (mWait > 0)) begin bad++; $display("[TB] FAIL rnd_busy n=%0d got=%0b want=%0b", n, busy, (mWait > 0)); end
      total++; if (alu_ctrl !== mCtrl) begin bad++; $display("[TB] FAIL rnd_ctrl n=%0d got=%b want=%b", n, alu_ctrl, mCtrl); end
      total++; if (illegal !== mIll) begin bad++; $display("[TB] FAIL rnd_illegal n=%0d got=%0b want=%0b", n, illegal, mIll); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_itype();
    test_muldiv();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule
